// File: rtl/mem_resp.sv
// Word-addressed memory responder with fixed-latency read/write completion.
// Requests are sampled in IDLE, optionally aged in BUSY, and completed in DONE.
module mem_resp #(
    parameter int unsigned AW      = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] MemData,
    output logic        MemRdy,
    output logic        MemErr
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            op_wr;
    logic [AW-1:0]   cap_idx;
    logic [31:0]     cap_data;
    logic [31:0]     mem [DEPTH];

    logic            bad_c;
    logic            accept_c;
    logic            reject_c;
    logic            direct_c;
    logic            finish_c;
    logic            acc_wr_c;
    logic [AW-1:0]   acc_idx_c;
    logic [31:0]     acc_data_c;

    // Request qualification and selection of the access that completes this edge
    always_comb begin
        bad_c      = (MemRd & MemWr) | (Addr[1:0] != 2'b00) | ((Addr >> (AW + 2)) != 32'd0);
        accept_c   = (state == IDLE) & (MemRd | MemWr) & ~bad_c;
        reject_c   = (state == IDLE) & (MemRd | MemWr) & bad_c;
        direct_c   = (LATENCY == 1) & accept_c;
        finish_c   = direct_c | ((state == BUSY) & (cnt == 4'd0));
        acc_wr_c   = op_wr;
        acc_idx_c  = cap_idx;
        acc_data_c = cap_data;
        if (direct_c) begin
            // Single-cycle latency completes straight from the live inputs
            acc_wr_c   = MemWr;
            acc_idx_c  = Addr[AW+1:2];
            acc_data_c = WrData;
        end
    end

    // Storage array: never reset, written only on the edge entering DONE
    always_ff @(posedge CLK) begin
        if (finish_c && acc_wr_c) begin
            mem[acc_idx_c] <= acc_data_c;
        end
    end

    // Control FSM, request capture and registered response outputs
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            op_wr    <= 1'b0;
            cap_idx  <= '0;
            cap_data <= 32'd0;
            MemData  <= 32'd0;
            MemRdy   <= 1'b0;
            MemErr   <= 1'b0;
        end else begin
            MemRdy <= 1'b0;
            MemErr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (reject_c) begin
                        MemErr <= 1'b1;
                    end else if (accept_c) begin
                        op_wr    <= MemWr;
                        cap_idx  <= Addr[AW+1:2];
                        cap_data <= WrData;
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (finish_c) begin
                MemRdy <= 1'b1;
                if (!acc_wr_c) begin
                    MemData <= mem[acc_idx_c];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: LATENCY=2 instance driven through a scoreboard,
// plus a LATENCY=1 instance for back-to-back streaming.
module tb_mem_resp;

    localparam int unsigned LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        rd, wr, rd1, wr1;
    logic [31:0] addr, wdata, addr1, wdata1;
    logic [31:0] data, data1;
    logic        rdy, err, rdy1, err1;

    int compared;
    int mismatched;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model[int];
    logic [31:0] last_rd;

    mem_resp #(.AW(8), .LATENCY(LAT)) dut (
        .CLK(clk), .RST_n(rst_n), .MemRd(rd), .MemWr(wr), .Addr(addr),
        .WrData(wdata), .MemData(data), .MemRdy(rdy), .MemErr(err)
    );

    mem_resp #(.AW(8), .LATENCY(1)) dut1 (
        .CLK(clk), .RST_n(rst_n), .MemRd(rd1), .MemWr(wr1), .Addr(addr1),
        .WrData(wdata1), .MemData(data1), .MemRdy(rdy1), .MemErr(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on the LATENCY=2 instance; optionally alters Addr/WrData after capture
    task automatic access(input string tag, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit swap, input logic [31:0] alt_a, input logic [31:0] alt_d);
        exp_t e;
        int   n;
        bit   got;
        e.err = (r && w) || (a[1:0] != 2'b00) || (a >= 32'h400);
        e.rd  = r && !w;
        if (e.err)      e.data = last_rd;
        else if (e.rd)  e.data = model[int'(a[9:2])];
        else            e.data = 32'd0;
        if (!e.err && e.rd) last_rd = e.data;
        if (!e.err && w)    model[int'(a[9:2])] = d;
        sb.push_back(e);
        rd = r; wr = w; addr = a; wdata = d;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (swap && n == 1) begin
                addr = alt_a; wdata = alt_d;
            end
            if (rdy || err) got = 1'b1;
        end
        rd = 1'b0; wr = 1'b0;
        e = sb.pop_front();
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'(e.err));
        chk({tag, "_rdy"}, 32'(rdy), 32'(!e.err));
        chk({tag, "_cycles"}, 32'(n), e.err ? 32'd1 : 32'(LAT + 1));
        if (e.err || e.rd) chk({tag, "_data"}, data, e.data);
        tick();
        chk({tag, "_pulse_end"}, 32'({rdy, err}), 32'd0);
    endtask

    initial begin
        int pulses;
        compared = 0; mismatched = 0; last_rd = 32'd0;
        rd = 0; wr = 0; addr = 0; wdata = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_data", data, 32'd0);
        rst_n = 1'b1;

        // Write/read with latency check
        access("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
        access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0);

        // Rejected requests leave data and array untouched
        access("wr0", 1'b0, 1'b1, 32'h0, 32'hA5A50001, 1'b0, 32'h0, 32'h0);
        access("misalign", 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0, 32'h0);
        access("both", 1'b1, 1'b1, 32'h0, 32'h11111111, 1'b0, 32'h0, 32'h0);
        access("range", 1'b0, 1'b1, 32'h400, 32'h22222222, 1'b0, 32'h0, 32'h0);
        access("rd0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Reset during BUSY aborts a pending write
        wr = 1'b1; addr = 32'h0; wdata = 32'h1;
        tick();
        chk("abort_busy_rdy", 32'(rdy), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_async_data", data, 32'd0);
        chk("abort_async_rdy", 32'(rdy), 32'd0);
        wr = 1'b0;
        last_rd = 32'd0;
        repeat (3) begin
            tick();
            chk("abort_no_rdy", 32'(rdy), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("abort_idle_rdy", 32'(rdy), 32'd0);
        access("rd0_after_abort", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Address change after capture does not affect the read
        access("wr8", 1'b0, 1'b1, 32'h8, 32'h00000222, 1'b0, 32'h0, 32'h0);
        access("wrC", 1'b0, 1'b1, 32'hC, 32'h00000333, 1'b0, 32'h0, 32'h0);
        access("rd8_swap", 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'hC, 32'h0);
        access("wr_swap", 1'b0, 1'b1, 32'h8, 32'h00000444, 1'b1, 32'hC, 32'h00000555);
        access("rdC_after", 1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 32'h0, 32'h0);

        // Random writes then readback against the model
        for (int i = 0; i < 6; i++)
            access("rnd_wr", 1'b0, 1'b1, 32'((20 + i) * 4), $urandom, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++)
            access("rnd_rd", 1'b1, 1'b0, 32'((20 + i) * 4), 32'h0, 1'b0, 32'h0, 32'h0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // LATENCY=1: held read streams one completion every two cycles
        wr1 = 1'b1; addr1 = 32'h4; wdata1 = 32'h12345678;
        tick();
        chk("l1_wr_rdy", 32'(rdy1), 32'd1);
        wr1 = 1'b0;
        tick();
        chk("l1_wr_pulse_end", 32'(rdy1), 32'd0);
        rd1 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("l1_stream_rdy", 32'(rdy1), 32'(i % 2 == 0));
            if (rdy1) begin
                pulses++;
                chk("l1_stream_data", data1, 32'h12345678);
            end
        end
        rd1 = 1'b0;
        chk("l1_pulse_count", 32'(pulses), 32'd5);
        tick();
        chk("l1_quiet", 32'({rdy1, err1}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter AW, default 8, meaning word-address width (memory holds 2^AW 32-bit words).
REQ-002 Parameter LATENCY, default 2, meaning cycles from request sample to MemRdy; legal range 1..15.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RST_n  input  1  asynchronous active-low reset.
REQ-005 MemRd  input  1  read strobe from control unit, level, held by requester until MemRdy.
REQ-006 MemWr  input  1  write strobe from control unit, level, held by requester until MemRdy.
REQ-007 Addr  input  32  byte address (PC or ALUOut, selected upstream by IorD).
REQ-008 WrData  input  32  store data (register B).
REQ-009 MemData  output  32  read data, valid in the MemRdy cycle and held until the next completed read.
REQ-010 MemRdy  output  1  one-cycle completion pulse for an accepted read or write.
REQ-011 MemErr  output  1  one-cycle pulse for a rejected request.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-013 In IDLE, at each CLK edge, MemRd|MemWr SHALL be sampled as a request; Addr, WrData and the operation type are captured in the same edge.
REQ-014 A request SHALL be rejected when any of the following holds: MemRd&MemWr; Addr[1:0]!=0; Addr[31:AW+2]!=0.
REQ-015 A rejected request SHALL pulse MemErr high for exactly the cycle after the sampling edge, perform no array access, leave MemData unchanged, and keep the FSM in IDLE.
REQ-016 An accepted request SHALL move the FSM to BUSY and load a 4-bit down-counter with LATENCY-1.
REQ-017 In BUSY the counter SHALL decrement each edge; on the edge where it equals 0, the FSM SHALL move to DONE (for LATENCY=1, the transition is IDLE->DONE directly).
REQ-018 In DONE, MemRdy SHALL be high for exactly that cycle; the request is sampled at edge k and MemRdy is high in the cycle following edge k+LATENCY.
REQ-019 For a write, the array word at captured Addr[AW+1:2] SHALL be updated with captured WrData on the edge entering DONE.
REQ-020 For a read, MemData SHALL be loaded from the array on the edge entering DONE.
REQ-021 Inputs SHALL be ignored in BUSY and DONE; changes to Addr/WrData after capture SHALL NOT affect the access.
REQ-022 DONE SHALL always return to IDLE on the next edge; a strobe still high in that IDLE cycle SHALL be treated as a new request (back-to-back accesses, one IDLE cycle minimum between them).
REQ-023 A read from a word written by the immediately preceding write SHALL return the new data.
REQ-024 Array contents SHALL be undefined at power-up; no reset SHALL be applied to the array.

Reset
REQ-025 While RST_n=0: FSM=IDLE, counter=0, MemRdy=0, MemErr=0, MemData=32'h0, all asynchronously.
REQ-026 Reset asserted in BUSY SHALL abort the access: a pending write SHALL NOT modify the array, and no MemRdy is produced.
REQ-027 The first request SHALL be sampled on the first CLK edge with RST_n=1.

Verification
REQ-028 LATENCY=2: write Addr=32'h10, WrData=32'hDEADBEEF at edge 0 -> MemRdy=1 only in the cycle after edge 2; then read Addr=32'h10 -> MemData=32'hDEADBEEF with MemRdy.
REQ-029 MemRd=1, Addr=32'h13 -> MemErr pulse one cycle, MemRdy stays 0, MemData unchanged, FSM IDLE.
REQ-030 MemRd=MemWr=1, then separately Addr=32'h400 (AW=8) -> MemErr pulse for each; array word 0 unchanged.
REQ-031 Write 32'h1 to Addr 0, assert RST_n=0 during BUSY, release, read Addr 0 -> value equals the pre-write contents; no MemRdy during the aborted access.
REQ-032 LATENCY=1: MemRd held high for 10 cycles on Addr=32'h4 -> MemRdy pulses every 2 cycles, 5 pulses total.
REQ-033 Change Addr from 32'h8 to 32'hC one cycle after a read request is accepted -> MemData returns word 2, not word 3.
